// File: rtl/serial_word_xnor_cmp_pkg.sv
// rtl/serial_word_xnor_cmp_pkg.sv - shared FSM encoding, default width and counter-width helper
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_word_xnor_cmp_if.sv
// rtl/serial_word_xnor_cmp_if.sv - bit-pair stream and result bundle; mism_cnt exists only with MISMATCH_COUNT_EN
interface serial_word_xnor_cmp_if
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int CW = cw_of(WIDTH);

  logic start;
  logic bit_valid;
  logic a;
  logic b;
  logic busy;
  logic done;
  logic eq;
`ifdef MISMATCH_COUNT_EN
  logic [CW-1:0] mism_cnt;
`endif

`ifdef MISMATCH_COUNT_EN
  modport master (output start, bit_valid, a, b, input busy, done, eq, mism_cnt);
  modport slave  (input start, bit_valid, a, b, output busy, done, eq, mism_cnt);
`else
  modport master (output start, bit_valid, a, b, input busy, done, eq);
  modport slave  (input start, bit_valid, a, b, output busy, done, eq);
`endif

endinterface

// File: rtl/serial_word_xnor_cmp_xnor_nor.sv
// rtl/serial_word_xnor_cmp_xnor_nor.sv - 2-input XNOR built only from NOR gates
module xnor_nor (
  output logic y,
  input  logic a,
  input  logic b
);

  logic n_ab;
  logic n_a;
  logic n_b;

  // n_a = ~a & b and n_b = a & ~b, so their NOR is the XNOR
  assign n_ab = ~(a | b);
  assign n_a  = ~(a | n_ab);
  assign n_b  = ~(b | n_ab);
  assign y    = ~(n_a | n_b);

endmodule

// File: rtl/serial_word_xnor_cmp.sv
// rtl/serial_word_xnor_cmp.sv - serial word-equality comparator with registered eq and done strobe
// Optional mismatch counter on mism_cnt is built when MISMATCH_COUNT_EN is defined.
module serial_word_xnor_cmp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                     clk,
  input logic                     rst_n,
  serial_word_xnor_cmp_if.slave   bus
);

  localparam int CW = cw_of(WIDTH);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          eq_q;
  logic          bit_eq;
  logic          take;
  logic          last;
  logic          accept_start;

  xnor_nor u_xnor (
    .y (bit_eq),
    .a (bus.a),
    .b (bus.b)
  );

  assign accept_start = (state == IDLE) && bus.start;
  assign take         = (state == SHIFT) && bus.bit_valid;
  assign last         = take && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
  end

  // bit_eq only reaches the accumulator on accepted pairs, so X on idle cycles is masked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= 1'b1;
      eq_q <= 1'b0;
    end else if (accept_start) begin
      cnt  <= '0;
      acc  <= 1'b1;
      eq_q <= 1'b0;
    end else if (take) begin
      cnt <= cnt + CW'(1);
      acc <= acc & bit_eq;
      if (last) eq_q <= acc & bit_eq;
    end
  end

  assign bus.eq = eq_q;

`ifdef MISMATCH_COUNT_EN
  logic [CW-1:0] mism_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mism_q <= '0;
    end else if (accept_start) begin
      mism_q <= '0;
    end else if (take && !bit_eq && (mism_q != CW'(WIDTH))) begin
      mism_q <= mism_q + CW'(1);
    end
  end

  assign bus.mism_cnt = mism_q;
`endif

endmodule

// File: tb/tb_serial_word_xnor_cmp.sv
// tb/tb_serial_word_xnor_cmp.sv - randomized self-checking bench for serial_word_xnor_cmp (WIDTH=4)
module tb_serial_word_xnor_cmp;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_word_xnor_cmp_if #(.WIDTH(W)) bus ();

  serial_word_xnor_cmp #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] get_mism();
`ifdef MISMATCH_COUNT_EN
    return bus.mism_cnt;
`else
    return '0;
`endif
  endfunction

  // reference: equal iff words match, mismatch count is the popcount of the difference
  function automatic logic ref_eq(input logic [W-1:0] wa, input logic [W-1:0] wb);
    return (wa == wb);
  endfunction

  function automatic logic [CW-1:0] ref_mism(input logic [W-1:0] wa, input logic [W-1:0] wb);
`ifdef MISMATCH_COUNT_EN
    return CW'($countones(wa ^ wb));
`else
    return '0;
`endif
  endfunction

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a         = 1'b0;
    bus.b         = 1'b0;
  endtask

  // one full comparison, MSB first; returns observations for the calling test to judge
  task automatic run_word(input logic [W-1:0] wa, input logic [W-1:0] wb, input int gap,
                          input bit vstart, input bit smid, input bit xgap,
                          output int dcnt, output bit busy_ok, output bit lat_ok,
                          output logic eq0, output logic eqd, output logic [CW-1:0] md);
    dcnt = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bit_valid = vstart;
    bus.a = 1'b1;
    bus.b = 1'b0;
    @(negedge clk);
    eq0 = bus.eq;
    for (int i = W - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        busy_ok &= (bus.busy === 1'b1);
        dcnt += (bus.done === 1'b1) ? 1 : 0;
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a = xgap ? 1'bx : 1'($urandom);
        bus.b = xgap ? 1'bx : 1'($urandom);
        @(negedge clk);
      end
      busy_ok &= (bus.busy === 1'b1);
      dcnt += (bus.done === 1'b1) ? 1 : 0;
      bus.start = smid && (i == W / 2);
      bus.bit_valid = 1'b1;
      bus.a = wa[i];
      bus.b = wb[i];
      @(negedge clk);
    end
    lat_ok = (bus.done === 1'b1) && (bus.busy === 1'b0);
    eqd = bus.eq;
    md = get_mism();
    drive_idle();
    repeat (4) begin
      dcnt += (bus.done === 1'b1) ? 1 : 0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.eq !== 1'b0 || get_mism() !== '0) begin
      errors++;
      $display("FAIL reset_values busy=%b done=%b eq=%b mism=%0d required 0 0 0 0",
               bus.busy, bus.done, bus.eq, get_mism());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_word(input string name, input logic [W-1:0] wa, input logic [W-1:0] wb,
                            input int gap, input bit vstart, input bit smid, input bit xgap);
    int dcnt;
    bit busy_ok, lat_ok;
    logic eq0, eqd;
    logic [CW-1:0] md;
    run_word(wa, wb, gap, vstart, smid, xgap, dcnt, busy_ok, lat_ok, eq0, eqd, md);
    checks++;
    if (eq0 !== 1'b0) begin
      errors++;
      $display("FAIL %s eq_cleared_on_start got %b required 0", name, eq0);
    end
    checks++;
    if (eqd !== ref_eq(wa, wb)) begin
      errors++;
      $display("FAIL %s eq a=%b b=%b got %b required %b", name, wa, wb, eqd, ref_eq(wa, wb));
    end
    checks++;
    if (md !== ref_mism(wa, wb)) begin
      errors++;
      $display("FAIL %s mism_cnt got %0d required %0d", name, md, ref_mism(wa, wb));
    end
    checks++;
    if (dcnt !== 1 || !lat_ok) begin
      errors++;
      $display("FAIL %s done pulses=%0d on_time=%0b required 1 1", name, dcnt, lat_ok);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_during_shift got low required high", name);
    end
  endtask

  task automatic test_consecutive();
    check_word("consecutive", 4'b1011, 4'b1011, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    check_word("gaps", 4'b1011, 4'b1001, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    check_word("all_mismatch", 4'b0000, 4'b1111, 0, 1'b0, 1'b0, 1'b0);
    check_word("restart_match", 4'b0101, 4'b0101, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    check_word("start_ignored", 4'b1111, 4'b1111, 1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_x_gap();
    check_word("x_gap", 4'b1111, 4'b1111, 2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_shift();
    int dcnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bit_valid = 1'b1;
    bus.a = 1'b1;
    bus.b = 1'b0;
    repeat (2) @(negedge clk);
    bus.bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.eq !== 1'b0 || get_mism() !== '0) begin
      errors++;
      $display("FAIL reset_mid_shift busy=%b done=%b eq=%b mism=%0d required 0 0 0 0",
               bus.busy, bus.done, bus.eq, get_mism());
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.bit_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      dcnt += (bus.done === 1'b1 || bus.busy === 1'b1) ? 1 : 0;
    end
    drive_idle();
    checks++;
    if (dcnt !== 0) begin
      errors++;
      $display("FAIL reset_no_resume active_cycles=%0d required 0", dcnt);
    end
    check_word("after_reset", 4'b1011, 4'b1011, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_done();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bit_valid = 1'b1;
    bus.a = 1'b0;
    bus.b = 1'b0;
    repeat (W) @(negedge clk);
    drive_idle();
    checks++;
    if (bus.done !== 1'b1 || bus.eq !== 1'b1) begin
      errors++;
      $display("FAIL done_before_reset done=%b eq=%b required 1 1", bus.done, bus.eq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.eq !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done done=%b eq=%b busy=%b required 0 0 0", bus.done, bus.eq, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_in_done();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bit_valid = 1'b1;
    bus.a = 1'b1;
    bus.b = 1'b1;
    repeat (W) @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.eq !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done busy=%b done=%b eq=%b required 0 0 1", bus.busy, bus.done, bus.eq);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [W-1:0] wa, wb;
    for (int n = 0; n < 16; n++) begin
      wa = W'($urandom);
      wb = ($urandom_range(0, 1) == 1) ? wa : W'($urandom);
      check_word("random", wa, wb, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_consecutive();
    test_gaps();
    test_restart();
    test_start_ignored();
    test_x_gap();
    test_reset_mid_shift();
    test_reset_in_done();
    test_start_in_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
